seq_timing_decoder: RTL and testbench



---
 rtl/seq_timing_decoder.sv | 115 +++++++++++
 tb/tb_seq_timing_decoder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seq_timing_decoder.sv
// Sequence counter, instruction register and start flag for the control unit,
// with one-hot timing (T) and opcode (D) decodes. Optional macro: SINGLE_STEP_EN.
module seq_timing_decoder #(
   parameter int SC_WIDTH = 4,
   parameter int IR_WIDTH = 16
) (
   input  logic                       Clk,
   input  logic                       Reset_n,
   input  logic                       CLR_SC,
   input  logic                       INR_SC,
   input  logic                       LD_IR,
   input  logic [IR_WIDTH-1:0]        BUS,
   input  logic                       Set_S,
   input  logic                       Clear_S,
`ifdef SINGLE_STEP_EN
   input  logic                       Step,
`endif
   output logic [SC_WIDTH-1:0]        SC,
   output logic [(2**SC_WIDTH)-1:0]   T,
   output logic [IR_WIDTH-1:0]        IR,
   output logic [7:0]                 D,
   output logic                       I,
   output logic [11:0]                B,
   output logic                       S,
   output logic                       SC_Overflow
);

   localparam logic [SC_WIDTH-1:0] SC_MAX = {SC_WIDTH{1'b1}};

   logic [SC_WIDTH-1:0] sc_reg, sc_next;
   logic [IR_WIDTH-1:0] ir_reg, ir_next;
   logic                s_reg, s_next;
   logic                ovf_reg, ovf_next;

`ifdef SINGLE_STEP_EN
   logic                step_d_reg;
   logic                step_rise;
   logic                instr_end;

   assign step_rise = Step && !step_d_reg;
   assign instr_end = CLR_SC && (sc_reg != '0) && s_reg;
`endif

   always_comb begin
      sc_next  = sc_reg;
      ovf_next = ovf_reg;
      if (CLR_SC) begin
         sc_next = '0;
      end else if (INR_SC) begin
         sc_next = sc_reg + 1'b1;
         if (sc_reg == SC_MAX) begin
            ovf_next = 1'b1;
         end
      end

      ir_next = LD_IR ? BUS : ir_reg;

      // Set sources dominate clear sources so a restart is never lost.
`ifdef SINGLE_STEP_EN
      if (Set_S || step_rise) begin
         s_next = 1'b1;
      end else if (Clear_S || instr_end) begin
         s_next = 1'b0;
      end else begin
         s_next = s_reg;
      end
`else
      if (Set_S) begin
         s_next = 1'b1;
      end else if (Clear_S) begin
         s_next = 1'b0;
      end else begin
         s_next = s_reg;
      end
`endif
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         sc_reg     <= '0;
         ir_reg     <= '0;
         s_reg      <= 1'b1;
         ovf_reg    <= 1'b0;
`ifdef SINGLE_STEP_EN
         step_d_reg <= 1'b0;
`endif
      end else begin
         sc_reg     <= sc_next;
         ir_reg     <= ir_next;
         s_reg      <= s_next;
         ovf_reg    <= ovf_next;
`ifdef SINGLE_STEP_EN
         step_d_reg <= Step;
`endif
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < (2**SC_WIDTH); gi++) begin : g_t_decode
         assign T[gi] = (sc_reg == SC_WIDTH'(gi));
      end
      for (gi = 0; gi < 8; gi++) begin : g_d_decode
         assign D[gi] = (ir_reg[14:12] == 3'(gi));
      end
   endgenerate

   assign SC          = sc_reg;
   assign IR          = ir_reg;
   assign I           = ir_reg[15];
   assign B           = ir_reg[11:0];
   assign S           = s_reg;
   assign SC_Overflow = ovf_reg;

endmodule

// File: tb/tb_seq_timing_decoder.sv
// Self-checking bench for seq_timing_decoder: vector table plus hand-written
// overflow, reset and (with SINGLE_STEP_EN) single-step sequences.
module tb_seq_timing_decoder;

   logic        Clk = 1'b0;
   logic        Reset_n, CLR_SC, INR_SC, LD_IR, Set_S, Clear_S;
   logic [15:0] BUS;
   logic [3:0]  SC;
   logic [15:0] T, IR;
   logic [7:0]  D;
   logic        I, S, SC_Overflow;
   logic [11:0] B;
`ifdef SINGLE_STEP_EN
   logic        Step = 1'b0;
   localparam bit SS = 1'b1;
`else
   localparam bit SS = 1'b0;
`endif

   int total = 0;
   int bad   = 0;
   int txn   = 0;

   typedef struct {
      logic [3:0]  sc;
      logic [15:0] ir;
      logic        s;
      logic        ovf;
   } exp_t;

   typedef struct {
      logic        rst_n, clr, inr, ld;
      logic [15:0] bus;
      logic        set_s, clr_s;
      logic [3:0]  e_sc;
      logic [15:0] e_ir;
      logic        e_s, e_ovf;
   } vec_t;

   exp_t sb_q[$];
   vec_t vec[15];

   seq_timing_decoder dut (
      .Clk(Clk), .Reset_n(Reset_n), .CLR_SC(CLR_SC), .INR_SC(INR_SC),
      .LD_IR(LD_IR), .BUS(BUS), .Set_S(Set_S), .Clear_S(Clear_S),
`ifdef SINGLE_STEP_EN
      .Step(Step),
`endif
      .SC(SC), .T(T), .IR(IR), .D(D), .I(I), .B(B), .S(S),
      .SC_Overflow(SC_Overflow)
   );

   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s txn=%0d: got=%h required=%h", name, txn, got, req);
      end
   endtask

   task automatic drive(input logic rst_n, clr, inr, ld, input logic [15:0] bus,
                        input logic set_s, clr_s, input logic [3:0] e_sc,
                        input logic [15:0] e_ir, input logic e_s, e_ovf);
      exp_t e;
      logic [15:0] t_exp;
      logic [7:0]  d_exp;
      Reset_n = rst_n; CLR_SC = clr; INR_SC = inr; LD_IR = ld;
      BUS = bus; Set_S = set_s; Clear_S = clr_s;
      e.sc = e_sc; e.ir = e_ir; e.s = e_s; e.ovf = e_ovf;
      sb_q.push_back(e);
      @(posedge Clk);
      #1;
      if (sb_q.size() == 0) begin
         total++; bad++;
         $display("FAIL scoreboard txn=%0d: got=empty required=entry", txn);
      end else begin
         e = sb_q.pop_front();
         t_exp = 16'h0001 << e.sc;
         d_exp = 8'h01 << e.ir[14:12];
         chk("SC", 32'(SC), 32'(e.sc));
         chk("T", 32'(T), 32'(t_exp));
         chk("IR", 32'(IR), 32'(e.ir));
         chk("D", 32'(D), 32'(d_exp));
         chk("I", 32'(I), 32'(e.ir[15]));
         chk("B", 32'(B), 32'(e.ir[11:0]));
         chk("S", 32'(S), 32'(e.s));
         chk("SC_Overflow", 32'(SC_Overflow), 32'(e.ovf));
      end
      $display("txn %0d: rst_n=%b clr=%b inr=%b ld=%b bus=%h -> SC=%0d T=%h IR=%h D=%h S=%b ovf=%b",
               txn, rst_n, clr, inr, ld, bus, SC, T, IR, D, S, SC_Overflow);
      txn++;
   endtask

   initial begin
      //          rst clr inr ld  bus       set clrs  sc  ir        s          ovf
      vec[0]  = '{0, 0, 0, 0, 16'h0000, 0, 0, 4'd0, 16'h0000, 1'b1,      1'b0};
      vec[1]  = '{0, 0, 1, 1, 16'hFFFF, 0, 1, 4'd0, 16'h0000, 1'b1,      1'b0};
      vec[2]  = '{1, 0, 0, 0, 16'h0000, 0, 0, 4'd0, 16'h0000, 1'b1,      1'b0};
      vec[3]  = '{1, 0, 1, 0, 16'h0000, 0, 0, 4'd1, 16'h0000, 1'b1,      1'b0};
      vec[4]  = '{1, 0, 1, 0, 16'h0000, 0, 0, 4'd2, 16'h0000, 1'b1,      1'b0};
      vec[5]  = '{1, 0, 1, 0, 16'h0000, 0, 0, 4'd3, 16'h0000, 1'b1,      1'b0};
      vec[6]  = '{1, 1, 1, 0, 16'h0000, 0, 0, 4'd0, 16'h0000, SS ? 1'b0 : 1'b1, 1'b0};
      vec[7]  = '{1, 0, 0, 1, 16'hB123, 0, 0, 4'd0, 16'hB123, SS ? 1'b0 : 1'b1, 1'b0};
      vec[8]  = '{1, 0, 0, 0, 16'h5555, 0, 0, 4'd0, 16'hB123, SS ? 1'b0 : 1'b1, 1'b0};
      vec[9]  = '{1, 1, 0, 1, 16'h7FFF, 0, 0, 4'd0, 16'h7FFF, SS ? 1'b0 : 1'b1, 1'b0};
      vec[10] = '{1, 0, 0, 0, 16'h0000, 0, 1, 4'd0, 16'h7FFF, 1'b0,      1'b0};
      vec[11] = '{1, 0, 0, 0, 16'h0000, 1, 1, 4'd0, 16'h7FFF, 1'b1,      1'b0};
      vec[12] = '{1, 0, 0, 0, 16'h0000, 0, 1, 4'd0, 16'h7FFF, 1'b0,      1'b0};
      vec[13] = '{1, 0, 0, 0, 16'h0000, 0, 0, 4'd0, 16'h7FFF, 1'b0,      1'b0};
      vec[14] = '{1, 0, 0, 0, 16'h0000, 1, 0, 4'd0, 16'h7FFF, 1'b1,      1'b0};

      for (int i = 0; i < 15; i++) begin
         drive(vec[i].rst_n, vec[i].clr, vec[i].inr, vec[i].ld, vec[i].bus,
               vec[i].set_s, vec[i].clr_s, vec[i].e_sc, vec[i].e_ir,
               vec[i].e_s, vec[i].e_ovf);
      end

      // Count to 15, then clear: clearing at 15 must not flag overflow.
      for (int i = 0; i < 15; i++) begin
         drive(1, 0, 1, 0, 16'h0, 0, 0, 4'(i + 1), 16'h7FFF, 1'b1, 1'b0);
      end
      drive(1, 1, 0, 0, 16'h0, 0, 0, 4'd0, 16'h7FFF, SS ? 1'b0 : 1'b1, 1'b0);
      drive(1, 0, 0, 0, 16'h0, 1, 0, 4'd0, 16'h7FFF, 1'b1, 1'b0);

      // Sixteen increments wrap 15->0 and set the sticky flag on the last one.
      for (int i = 0; i < 16; i++) begin
         drive(1, 0, 1, 0, 16'h0, 0, 0, 4'((i + 1) % 16), 16'h7FFF, 1'b1, (i == 15));
      end
      drive(1, 1, 0, 0, 16'h0, 0, 0, 4'd0, 16'h7FFF, 1'b1, 1'b1);
      drive(1, 0, 1, 1, 16'h1234, 0, 1, 4'd1, 16'h1234, 1'b0, 1'b1);
      drive(1, 0, 1, 0, 16'h0, 0, 0, 4'd2, 16'h1234, 1'b0, 1'b1);

      // Mid-instruction reset with competing inputs returns everything to reset values.
      drive(0, 0, 1, 1, 16'hFFFF, 0, 1, 4'd0, 16'h0000, 1'b1, 1'b0);
      drive(1, 0, 0, 0, 16'h0, 0, 0, 4'd0, 16'h0000, 1'b1, 1'b0);

`ifdef SINGLE_STEP_EN
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 1, 0, 16'h0, 0, 0, 4'(i + 1), 16'h0000, 1'b1, 1'b0);
      end
      drive(1, 1, 0, 0, 16'h0, 0, 0, 4'd0, 16'h0000, 1'b0, 1'b0);
      Step = 1'b1;
      drive(1, 0, 0, 0, 16'h0, 0, 0, 4'd0, 16'h0000, 1'b1, 1'b0);
      drive(1, 0, 1, 0, 16'h0, 0, 0, 4'd1, 16'h0000, 1'b1, 1'b0);
      drive(1, 1, 0, 0, 16'h0, 0, 0, 4'd0, 16'h0000, 1'b0, 1'b0);
      drive(1, 0, 0, 0, 16'h0, 0, 0, 4'd0, 16'h0000, 1'b0, 1'b0);
      Step = 1'b0;
      drive(1, 0, 0, 0, 16'h0, 0, 0, 4'd0, 16'h0000, 1'b0, 1'b0);
      Step = 1'b1;
      drive(1, 0, 1, 0, 16'h0, 0, 0, 4'd1, 16'h0000, 1'b1, 1'b0);
      // Set_S overrides the instruction-end clear.
      drive(1, 1, 0, 0, 16'h0, 1, 0, 4'd0, 16'h0000, 1'b1, 1'b0);
      Step = 1'b0;
`endif

      if (sb_q.size() != 0) begin
         total++; bad++;
         $display("FAIL scoreboard_drain: got=%0d required=0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
